skullfet_cell_tester: RTL
=========================

Name: skullfet_cell_tester

Overview:
- On-chip stimulus/checker for the SkullFET inverter and NAND blackbox cells.
- Drives the cell inputs through an exhaustive pattern sweep, waits for settling, samples the asynchronous cell outputs through synchronizers, and compares them against the expected truth table.
- Reports pass/fail and captures the first mismatch.
- Sits in the project top between the user I/O pins and the skullfet cell instances.

Parameters:
- SETTLE_CYCLES, 4, cycles waited after applying a pattern, before the synchronizer delay is counted.
- SYNC_STAGES, 2, flop stages on each cell output (minimum 2).
- ITER_W, 8, width of the sweep counter and of loop_count.
- STOP_ON_FAIL, 1, 1 = halt the run at the first mismatch; 0 = finish all sweeps.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE.
- stop  input  1  abort the run; effective in any busy state.
- loop_count  input  ITER_W  number of full sweeps; 0 = run continuously.
- inv_a  output  1  drives inverter input A.
- inv_y  input  1  inverter output Y (asynchronous).
- nand_a  output  1  drives NAND input A.
- nand_b  output  1  drives NAND input B.
- nand_y  input  1  NAND output Y (asynchronous).
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse on normal or fail completion.
- pass  output  1  last run completed with no mismatch; held until the next start.
- fail_cell  output  2  sticky first-mismatch cells: bit0 = inverter, bit1 = NAND.
- fail_pattern  output  2  pattern index of the first mismatch.
- sweeps_done  output  ITER_W  completed sweeps in the current/last run.

Behaviour:
- Reset (synchronous, active-high): state IDLE; all outputs 0.
- Pattern p[1:0] counts 0..3 per sweep. Drive assignments:
  - inv_a = p[0]
  - nand_a = p[1]
  - nand_b = p[0]
- Expected outputs:
  - inv_y = ~p[0]
  - nand_y = ~(p[1] & p[0])
- Inv and NAND outputs each pass through a SYNC_STAGES synchronizer before comparison.
- FSM states:
  - IDLE: on start, clear pass, fail_cell, fail_pattern, sweeps_done; set p = 0; go to APPLY. busy rises the cycle after start is sampled.
  - APPLY (1 cycle): drive the pattern; load wait counter = SETTLE_CYCLES + SYNC_STAGES − 1.
  - WAIT (SETTLE_CYCLES + SYNC_STAGES cycles): count down to 0, then go to CHECK.
  - CHECK (1 cycle): compare synchronized outputs with expected.
    - On a mismatch with fail_cell == 0, capture fail_cell bits and fail_pattern = p.
    - Mismatch and STOP_ON_FAIL = 1 → DONE.
    - Otherwise, p == 3 → increment sweeps_done (saturating). Then, if loop_count != 0 and sweeps_done + 1 == loop_count → DONE; else p = 0 → APPLY.
    - Otherwise → p + 1 → APPLY.
  - DONE (1 cycle): done = 1; pass = (fail_cell == 0); busy = 0 next cycle; return to IDLE.
- Per-step latency = SETTLE_CYCLES + SYNC_STAGES + 2 cycles (8 by default); one sweep = 32 cycles.
- Drive outputs hold the pattern through WAIT and CHECK; all drive outputs are 0 in IDLE.
- Boundary conditions:
  - start while busy: ignored.
  - stop and start asserted together in IDLE: stop wins, no run starts.
  - stop in any busy state: next cycle → IDLE with busy = 0; no done; pass = 0; captured results retained.
  - stop coinciding with the final CHECK: stop wins.
  - rst mid-run: all state and outputs 0 on the next edge.
  - loop_count = 0: run until stop, or until a fail when STOP_ON_FAIL = 1.
  - sweeps_done saturates at its maximum value.

Optional Feature:
- Macro: SKULLFET_ERRCNT_EN.
- Defined: adds output port err_count (8 bits), a saturating count of CHECK cycles with any mismatch. It is cleared on start and on rst. With STOP_ON_FAIL = 1 it reaches at most 1.
- Undefined: no port and no counter logic; all other behaviour identical.

Decomposition:
- Package skullfet_pkg holds:
  - tester state enum (IDLE, APPLY, WAIT, CHECK, DONE);
  - NUM_PATTERNS = 4;
  - expected-output function taking p and returning {nand_exp, inv_exp}.
- Sub-module skullfet_sync: a parameterized SYNC_STAGES flop chain with synchronous reset to 0, instantiated once per cell output.

Test Plan:
1. Ideal cell models, loop_count = 1, start → busy high for 32 cycles, single done pulse, pass = 1, fail_cell = 0, sweeps_done = 1.
2. NAND modelled stuck at 1, STOP_ON_FAIL = 1, loop_count = 2 → done at first sweep p = 3 CHECK, fail_cell = 2'b10, fail_pattern = 3, pass = 0, sweeps_done = 0.
3. Inverter modelled as a buffer → fail at p = 0, fail_cell = 2'b01, fail_pattern = 0, done 8 cycles after busy rises.
4. loop_count = 0, ideal models, stop asserted 100 cycles after start → busy low next cycle, no done pulse, sweeps_done = 3, drive outputs 0.
5. rst asserted in the WAIT of the second sweep → next cycle all outputs 0, state IDLE; a subsequent start runs normally.
6. SKULLFET_ERRCNT_EN defined, STOP_ON_FAIL = 0, NAND stuck at 1, loop_count = 3 → err_count = 3, fail_cell = 2'b10, fail_pattern = 3, pass = 0, sweeps_done = 3.

Source files
------------

// File: rtl/skullfet_pkg.sv
// ---------------------------------------------------------------------------
// skullfet_pkg: shared states, pattern count and truth table for the tester
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package skullfet_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    APPLY = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } tester_state_t;

  localparam int NUM_PATTERNS = 4;

  // Returns {nand_exp, inv_exp} for pattern p (inv_a = p[0], nand = p[1], p[0]).
  function automatic logic [1:0] expected_outputs(input logic [1:0] p);
    return {~(p[1] & p[0]), ~p[0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/skullfet_sync.sv
// ---------------------------------------------------------------------------
// skullfet_sync: STAGES-deep flop chain for one asynchronous cell output
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module skullfet_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/skullfet_cell_tester.sv
// ---------------------------------------------------------------------------
// skullfet_cell_tester: exhaustive sweep checker for SkullFET INV/NAND cells.
// SKULLFET_ERRCNT_EN adds the err_count output. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module skullfet_cell_tester
  import skullfet_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int ITER_W        = 8,
  parameter int STOP_ON_FAIL  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [ITER_W-1:0] loop_count,
  output logic              inv_a,
  input  logic              inv_y,
  output logic              nand_a,
  output logic              nand_b,
  input  logic              nand_y,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_cell,
  output logic [1:0]        fail_pattern,
  output logic [ITER_W-1:0] sweeps_done
`ifdef SKULLFET_ERRCNT_EN
  ,
  output logic [7:0]        err_count
`endif
);

  localparam int WAIT_INIT = SETTLE_CYCLES + SYNC_STAGES - 1;
  localparam int WAIT_W    = (WAIT_INIT < 1) ? 1 : $clog2(WAIT_INIT + 1);

  tester_state_t     state, state_nxt;
  logic [1:0]        pat, pat_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              pass_nxt;
  logic [1:0]        fail_cell_nxt, fail_pattern_nxt;
  logic [ITER_W-1:0] sweeps_nxt;
  logic [ITER_W:0]   sweeps_plus1;
  logic              inv_s, nand_s;
  logic [1:0]        mismatch;
  logic              run_active;

  skullfet_sync #(.STAGES(SYNC_STAGES)) u_sync_inv (
    .clk(clk), .rst(rst), .d(inv_y), .q(inv_s)
  );

  skullfet_sync #(.STAGES(SYNC_STAGES)) u_sync_nand (
    .clk(clk), .rst(rst), .d(nand_y), .q(nand_s)
  );

  assign mismatch     = {nand_s, inv_s} ^ expected_outputs(pat);
  assign sweeps_plus1 = {1'b0, sweeps_done} + {{ITER_W{1'b0}}, 1'b1};
  assign run_active   = (state == APPLY) || (state == WAIT) || (state == CHECK);

  assign busy   = run_active;
  assign done   = (state == DONE);
  assign inv_a  = run_active & pat[0];
  assign nand_a = run_active & pat[1];
  assign nand_b = run_active & pat[0];

`ifdef SKULLFET_ERRCNT_EN
  logic [7:0] err_cnt, err_nxt;
  assign err_count = err_cnt;
`endif

  always_comb begin
    state_nxt        = state;
    pat_nxt          = pat;
    wait_nxt         = wait_cnt;
    pass_nxt         = pass;
    fail_cell_nxt    = fail_cell;
    fail_pattern_nxt = fail_pattern;
    sweeps_nxt       = sweeps_done;
`ifdef SKULLFET_ERRCNT_EN
    err_nxt          = err_cnt;
`endif
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nxt        = APPLY;
          pat_nxt          = 2'd0;
          pass_nxt         = 1'b0;
          fail_cell_nxt    = 2'd0;
          fail_pattern_nxt = 2'd0;
          sweeps_nxt       = '0;
`ifdef SKULLFET_ERRCNT_EN
          err_nxt          = 8'd0;
`endif
        end
      end
      APPLY: begin
        wait_nxt  = WAIT_W'(WAIT_INIT);
        state_nxt = WAIT;
      end
      WAIT: begin
        if (wait_cnt == '0) state_nxt = CHECK;
        else                wait_nxt  = wait_cnt - WAIT_W'(1);
      end
      CHECK: begin
        if (mismatch != 2'd0 && fail_cell == 2'd0) begin
          fail_cell_nxt    = mismatch;
          fail_pattern_nxt = pat;
        end
`ifdef SKULLFET_ERRCNT_EN
        if (mismatch != 2'd0 && err_cnt != 8'hFF) err_nxt = err_cnt + 8'd1;
`endif
        if (mismatch != 2'd0 && STOP_ON_FAIL != 0) begin
          state_nxt = DONE;
          pass_nxt  = 1'b0;
        end else if (pat == 2'(NUM_PATTERNS - 1)) begin
          if (sweeps_done != '1) sweeps_nxt = sweeps_plus1[ITER_W-1:0];
          if (loop_count != '0 && sweeps_plus1 == {1'b0, loop_count}) begin
            state_nxt = DONE;
            pass_nxt  = (fail_cell_nxt == 2'd0);
          end else begin
            pat_nxt   = 2'd0;
            state_nxt = APPLY;
          end
        end else begin
          pat_nxt   = pat + 2'd1;
          state_nxt = APPLY;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Abort discards whatever this cycle would have captured or counted.
    if (stop && run_active) begin
      state_nxt        = IDLE;
      pat_nxt          = pat;
      pass_nxt         = 1'b0;
      fail_cell_nxt    = fail_cell;
      fail_pattern_nxt = fail_pattern;
      sweeps_nxt       = sweeps_done;
`ifdef SKULLFET_ERRCNT_EN
      err_nxt          = err_cnt;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pat          <= 2'd0;
      wait_cnt     <= '0;
      pass         <= 1'b0;
      fail_cell    <= 2'd0;
      fail_pattern <= 2'd0;
      sweeps_done  <= '0;
`ifdef SKULLFET_ERRCNT_EN
      err_cnt      <= 8'd0;
`endif
    end else begin
      state        <= state_nxt;
      pat          <= pat_nxt;
      wait_cnt     <= wait_nxt;
      pass         <= pass_nxt;
      fail_cell    <= fail_cell_nxt;
      fail_pattern <= fail_pattern_nxt;
      sweeps_done  <= sweeps_nxt;
`ifdef SKULLFET_ERRCNT_EN
      err_cnt      <= err_nxt;
`endif
    end
  end

endmodule

`default_nettype wire
